// File: rtl/register_memory_param.sv
// Parametrised register bank: two combinational reads, one synchronous write, plus a self-clearing sweep after reset or clear.
// ready is low during the sweep, and writes made then are dropped. Forwarding is enabled with REGISTER_MEMORY_BYPASS_EN.
module register_memory_param #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 5,
   parameter int HARDWIRE_ZERO = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  regWrite,
   input  logic [ADDR_WIDTH-1:0] writeRegister,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic [ADDR_WIDTH-1:0] readRegister1,
   input  logic [ADDR_WIDTH-1:0] readRegister2,
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2,
   output logic                  ready
);

   localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_ptr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_en;
   logic                    wr_is_zero;
   logic                    rd1_is_zero;
   logic                    rd2_is_zero;

   assign wr_is_zero  = (HARDWIRE_ZERO != 0) && (writeRegister == '0);
   assign rd1_is_zero = (HARDWIRE_ZERO != 0) && (readRegister1 == '0);
   assign rd2_is_zero = (HARDWIRE_ZERO != 0) && (readRegister2 == '0);

   // clear outranks a same-cycle write
   assign wr_en = (state == READY) && regWrite && !clear && !wr_is_zero;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         ready   <= 1'b0;
      end else if (clear) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == LAST_IDX) begin
                  state <= READY;
                  ready <= 1'b1;
               end
            end
            READY: begin
               state <= READY;
               ready <= 1'b1;
            end
            default: begin
               state   <= CLEAR;
               clr_ptr <= '0;
               ready   <= 1'b0;
            end
         endcase
      end
   end

   // Array has no reset; the sweep is what zeroes it
   always_ff @(posedge clock) begin
      if (state == CLEAR) begin
         mem[clr_ptr] <= '0;
      end else if (wr_en) begin
         mem[writeRegister] <= writeData;
      end
   end

   always_comb begin
      readData1 = mem[readRegister1];
      if (!ready || rd1_is_zero) begin
         readData1 = '0;
`ifdef REGISTER_MEMORY_BYPASS_EN
      end else if (wr_en && (writeRegister == readRegister1)) begin
         readData1 = writeData;
`endif
      end
   end

   always_comb begin
      readData2 = mem[readRegister2];
      if (!ready || rd2_is_zero) begin
         readData2 = '0;
`ifdef REGISTER_MEMORY_BYPASS_EN
      end else if (wr_en && (writeRegister == readRegister2)) begin
         readData2 = writeData;
`endif
      end
   end

endmodule

// File: tb/tb_register_memory_param.sv
// Bench for register_memory_param: one instance with hard-wired r0 and one without, both driven by shared stimulus.
module tb_register_memory_param;

`ifdef REGISTER_MEMORY_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n;
   logic        clear;
   logic        regWrite;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic [4:0]  readRegister1;
   logic [4:0]  readRegister2;
   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
   logic        ready_a, ready_b;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] ma [32];
   logic [31:0] mb [32];
   bit          mready;
   logic [31:0] exp_q [$];

   register_memory_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .HARDWIRE_ZERO(1)) dut_a (
      .clock(clock), .reset_n(reset_n), .clear(clear), .regWrite(regWrite),
      .writeRegister(writeRegister), .writeData(writeData),
      .readRegister1(readRegister1), .readRegister2(readRegister2),
      .readData1(rd1_a), .readData2(rd2_a), .ready(ready_a)
   );

   register_memory_param #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .HARDWIRE_ZERO(0)) dut_b (
      .clock(clock), .reset_n(reset_n), .clear(clear), .regWrite(regWrite),
      .writeRegister(writeRegister), .writeData(writeData),
      .readRegister1(readRegister1), .readRegister2(readRegister2),
      .readData1(rd1_b), .readData2(rd2_b), .ready(ready_b)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic check_ready(input string tag, input bit exp);
      check({tag, "_ready_a"}, {31'b0, ready_a}, {31'b0, exp});
      check({tag, "_ready_b"}, {31'b0, ready_b}, {31'b0, exp});
   endtask

   // Push expectations for both ports of both instances, settle, then pop and compare
   task automatic rd_exp(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] ea1, input logic [31:0] ea2,
                         input logic [31:0] eb1, input logic [31:0] eb2, input string tag);
      readRegister1 = a1;
      readRegister2 = a2;
      exp_q.push_back(ea1);
      exp_q.push_back(ea2);
      exp_q.push_back(eb1);
      exp_q.push_back(eb2);
      #1;
      check({tag, "_a1"}, rd1_a, exp_q.pop_front());
      check({tag, "_a2"}, rd2_a, exp_q.pop_front());
      check({tag, "_b1"}, rd1_b, exp_q.pop_front());
      check({tag, "_b2"}, rd2_b, exp_q.pop_front());
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
      logic [31:0] ea1, ea2, eb1, eb2;
      ea1 = (!mready || a1 == 5'd0) ? 32'h0 : ma[a1];
      ea2 = (!mready || a2 == 5'd0) ? 32'h0 : ma[a2];
      eb1 = mready ? mb[a1] : 32'h0;
      eb2 = mready ? mb[a2] : 32'h0;
      rd_exp(a1, a2, ea1, ea2, eb1, eb2, tag);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      regWrite      = 1'b1;
      writeRegister = a;
      writeData     = d;
      tick();
      regWrite = 1'b0;
      if (mready) begin
         if (a != 5'd0) ma[a] = d;
         mb[a] = d;
      end
   endtask

   task automatic zero_model();
      for (int i = 0; i < 32; i++) begin
         ma[i] = 32'h0;
         mb[i] = 32'h0;
      end
   endtask

   // Counts edges until ready, bounded so a stuck sweep still reaches the summary
   task automatic sweep_wait(input string tag);
      int n;
      n = 0;
      while (!ready_a && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_edges"}, 32'(n), 32'd32);
      check({tag, "_ready_b"}, {31'b0, ready_b}, 32'd1);
      zero_model();
      mready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; regWrite = 1'b0;
      writeRegister = 5'd0; writeData = 32'h0;
      readRegister1 = 5'd5; readRegister2 = 5'd31;
      mready = 1'b0;
      zero_model();

      // Reset release and sweep timing
      #12;
      check_ready("rst_hold", 1'b0);
      rd_exp(5'd5, 5'd31, 32'h0, 32'h0, 32'h0, 32'h0, "rst_hold_rd");
      reset_n = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         tick();
         check_ready($sformatf("rst_edge%0d", e), e == 32);
         if (e < 32) rd_exp(5'd5, 5'd31, 32'h0, 32'h0, 32'h0, 32'h0, $sformatf("rst_rd%0d", e));
      end
      mready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rd(5'(i), 5'(31 - i), $sformatf("init_zero%0d", i));
         tick();
      end

      // Basic write / read and dual read
      wr(5'd5, 32'hDEADBEEF);
      wr(5'd31, 32'h12345678);
      rd_exp(5'd5, 5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, "basic");
      rd_exp(5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, "dual");

      // Zero register
      wr(5'd0, 32'hFFFFFFFF);
      rd_exp(5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, "r0");

      // Clear with a same-cycle write that must be dropped
      wr(5'd7, 32'hA5A5A5A5);
      rd(5'd7, 5'd8, "pre_clear");
      clear = 1'b1; regWrite = 1'b1; writeRegister = 5'd8; writeData = 32'h1;
      tick();
      clear = 1'b0; regWrite = 1'b0;
      mready = 1'b0;
      check_ready("clear_fall", 1'b0);
      sweep_wait("clear1");
      rd_exp(5'd7, 5'd8, 32'h0, 32'h0, 32'h0, 32'h0, "after_clear");

      // Clear re-asserted at sweep cycle 10
      wr(5'd7, 32'h0BADF00D);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mready = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      sweep_wait("clear2");
      rd(5'd7, 5'd0, "after_clear2");

      // Reset during READY: ready and reads drop at once
      wr(5'd3, 32'h00000099);
      rd(5'd3, 5'd3, "pre_rst");
      reset_n = 1'b0;
      mready = 1'b0;
      #1;
      check_ready("rst_async", 1'b0);
      rd_exp(5'd3, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0, "rst_async_rd");
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'h55;
      tick();
      regWrite = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      reset_n = 1'b0;
      #1;
      check_ready("rst_midsweep", 1'b0);
      tick();
      reset_n = 1'b1;
      sweep_wait("rst_sweep");
      rd(5'd3, 5'd5, "write_in_clear");

      // Forwarding (or its absence) in the write cycle
      wr(5'd9, 32'h1);
      regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h2;
      rd_exp(5'd9, 5'd9, BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1,
             BYP ? 32'h2 : 32'h1, BYP ? 32'h2 : 32'h1, "byp_same");
      tick();
      regWrite = 1'b0;
      ma[9] = 32'h2; mb[9] = 32'h2;
      rd(5'd9, 5'd9, "byp_after");

      regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'h7;
      rd_exp(5'd0, 5'd9, 32'h0, 32'h2, BYP ? 32'h7 : mb[0], 32'h2, "byp_r0");
      tick();
      regWrite = 1'b0;
      mb[0] = 32'h7;
      rd(5'd0, 5'd0, "r0_after");

      // No forwarding when clear is present in the same cycle
      regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h3; clear = 1'b1;
      rd_exp(5'd9, 5'd9, 32'h2, 32'h2, 32'h2, 32'h2, "byp_clear");
      tick();
      regWrite = 1'b0; clear = 1'b0;
      mready = 1'b0;
      sweep_wait("clear3");
      rd(5'd9, 5'd0, "after_clear3");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
